// File: rtl/aes_stream_loader.sv
// Stream front-end for a combinational AES-128 core: assembles a 4-word key and a 4-word block,
// samples the core after WAIT_CYC cycles, and serialises the ciphertext as four 32-bit words.
module aes_stream_loader #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_word,
    input  logic         in_is_key,
    output logic [127:0] core_key,
    output logic [127:0] core_data,
    input  logic [127:0] core_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_word,
    output logic         out_last,
    output logic         key_loaded,
    output logic         busy
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [NWORDS-1:0][WORD_W-1:0]   key_q, key_d;
    logic [NWORDS-1:0][WORD_W-1:0]   data_q, data_d;
    logic [NWORDS-1:0][WORD_W-1:0]   result_q, result_d;
    logic [IDX_W-1:0]                key_cnt_q, key_cnt_d;
    logic [IDX_W-1:0]                data_cnt_q, data_cnt_d;
    logic [IDX_W-1:0]                word_idx_q, word_idx_d;
    logic [CNT_W-1:0]                wait_cnt_q, wait_cnt_d;
    logic                            key_loaded_q, key_loaded_d;

    // Data words are only taken once a complete key is present.
    assign in_ready = (state_q == S_LOAD) && (in_is_key || key_loaded_q);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            key_q        <= '0;
            data_q       <= '0;
            result_q     <= '0;
            key_cnt_q    <= '0;
            data_cnt_q   <= '0;
            word_idx_q   <= '0;
            wait_cnt_q   <= '0;
            key_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            data_q       <= data_d;
            result_q     <= result_d;
            key_cnt_q    <= key_cnt_d;
            data_cnt_q   <= data_cnt_d;
            word_idx_q   <= word_idx_d;
            wait_cnt_q   <= wait_cnt_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    // Next-state logic; word slot ~cnt places the first word of a group in the top 32 bits.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        data_d       = data_q;
        result_d     = result_q;
        key_cnt_d    = key_cnt_q;
        data_cnt_d   = data_cnt_q;
        word_idx_d   = word_idx_q;
        wait_cnt_d   = wait_cnt_q;
        key_loaded_d = key_loaded_q;

        unique case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    if (in_is_key) begin
                        key_d[~key_cnt_q] = in_word;
                        key_cnt_d         = key_cnt_q + 2'd1;
                        if (key_cnt_q == 2'd0) key_loaded_d = 1'b0;
                        if (key_cnt_q == 2'd3) key_loaded_d = 1'b1;
                    end else begin
                        data_d[~data_cnt_q] = in_word;
                        data_cnt_d          = data_cnt_q + 2'd1;
                        if (data_cnt_q == 2'd3) begin
                            state_d    = S_WAIT;
                            wait_cnt_d = CNT_W'(WAIT_CYC);
                        end
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    wait_cnt_d = '0;
                    result_d   = core_result;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    word_idx_d = word_idx_q + 2'd1;
                    if (word_idx_q == 2'd3) state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign core_key   = key_q;
    assign core_data  = data_q;
    assign key_loaded = key_loaded_q;
    assign out_valid  = (state_q == S_SEND);
    assign out_word   = result_q[~word_idx_q];
    assign out_last   = (state_q == S_SEND) && (word_idx_q == 2'd3);
    assign busy       = (state_q != S_LOAD);

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed bench for aes_stream_loader; two instances (WAIT_CYC=1 and 4) share stimulus via sel,
// each with an XOR stand-in for the AES core.
module tb_aes_stream_loader;

    localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DATA  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXP1  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] DATA2 = 128'hffffffff0000000012345678deadbeef;
    localparam logic [127:0] EXP2  = 128'hfffefdfc040506071a3d5c73d2a0b0e0;

    logic clk, rst_n, sel;
    logic in_valid, in_is_key, out_ready;
    logic [31:0] in_word;

    logic         in_ready1, out_valid1, out_last1, key_loaded1, busy1;
    logic [31:0]  out_word1;
    logic [127:0] core_key1, core_data1, core_result1;
    logic         in_ready4, out_valid4, out_last4, key_loaded4, busy4;
    logic [31:0]  out_word4;
    logic [127:0] core_key4, core_data4, core_result4;

    logic         in_ready, out_valid, out_last, key_loaded, busy;
    logic [31:0]  out_word;
    logic [127:0] core_key, core_data;

    int checks = 0;
    int errors = 0;

    assign core_result1 = core_data1 ^ core_key1;
    assign core_result4 = core_data4 ^ core_key4;

    aes_stream_loader #(.WAIT_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(in_ready1), .in_word(in_word), .in_is_key(in_is_key),
        .core_key(core_key1), .core_data(core_data1), .core_result(core_result1),
        .out_valid(out_valid1), .out_ready(out_ready & ~sel), .out_word(out_word1),
        .out_last(out_last1), .key_loaded(key_loaded1), .busy(busy1)
    );

    aes_stream_loader #(.WAIT_CYC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(in_ready4), .in_word(in_word), .in_is_key(in_is_key),
        .core_key(core_key4), .core_data(core_data4), .core_result(core_result4),
        .out_valid(out_valid4), .out_ready(out_ready & sel), .out_word(out_word4),
        .out_last(out_last4), .key_loaded(key_loaded4), .busy(busy4)
    );

    assign in_ready   = sel ? in_ready4   : in_ready1;
    assign out_valid  = sel ? out_valid4  : out_valid1;
    assign out_last   = sel ? out_last4   : out_last1;
    assign key_loaded = sel ? key_loaded4 : key_loaded1;
    assign busy       = sel ? busy4       : busy1;
    assign out_word   = sel ? out_word4   : out_word1;
    assign core_key   = sel ? core_key4   : core_key1;
    assign core_data  = sel ? core_data4  : core_data1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Offer one word and hold it until accepted (bounded); returns 1 ns after the accepting edge.
    task automatic push(input logic [31:0] w, input logic k);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_word = w; in_is_key = k;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_accept: word %h never accepted (in_ready=%b, required 1)", w, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic load_block(input logic [127:0] v, input logic k);
        logic [127:0] t;
        t = v;
        for (int i = 0; i < 4; i++) push(t[127-32*i -: 32], k);
    endtask

    // Count rising edges until out_valid is seen (bounded).
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_is_key = 1'b0; in_word = '0; out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || key_loaded !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b busy=%b key_loaded=%b last=%b, required all 0",
                     out_valid, busy, key_loaded, out_last);
        end
        checks++;
        if (core_key !== '0 || core_data !== '0) begin
            errors++;
            $display("FAIL reset_regs: key=%h data=%h, required 0", core_key, core_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_key_gate;
        sel = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_is_key = 1'b0; in_word = 32'h00112233;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL gate_refuse: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (core_data !== '0) begin
            errors++;
            $display("FAIL gate_not_consumed: core_data=%h, required 0", core_data);
        end
        load_block(KEY, 1'b1);
        checks++;
        if (key_loaded !== 1'b1 || core_key !== KEY) begin
            errors++;
            $display("FAIL gate_key: key_loaded=%b core_key=%h, required 1 / %h", key_loaded, core_key, KEY);
        end
        @(negedge clk);
        in_valid = 1'b1; in_is_key = 1'b0; in_word = 32'h00112233;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL gate_accept: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic;
        int n;
        logic [127:0] e;
        e = EXP1;
        sel = 1'b0; out_ready = 1'b1;
        load_block(DATA, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || core_data !== DATA) begin
            errors++;
            $display("FAIL basic_wait: valid=%b busy=%b data=%h, required 0 / 1 / %h", out_valid, busy, core_data, DATA);
        end
        wait_out(n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL basic_latency: %0d edges, required 1", n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_word !== e[127-32*i -: 32] || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL basic_word%0d: valid=%b word=%h last=%b, required 1 / %h / %b",
                         i, out_valid, out_word, out_last, e[127-32*i -: 32], (i == 3));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: valid=%b busy=%b last=%b, required 0", out_valid, busy, out_last);
        end
    endtask

    task automatic test_backpressure;
        int n;
        logic [127:0] e;
        e = EXP1;
        sel = 1'b0; out_ready = 1'b0;
        load_block(DATA, 1'b0);
        wait_out(n);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_word !== 32'h00102030 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b word=%h last=%b, required 1 / 00102030 / 0",
                         c, out_valid, out_word, out_last);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_word !== e[127-32*i -: 32] || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL bp_word%0d: valid=%b word=%h last=%b, required 1 / %h / %b",
                         i, out_valid, out_word, out_last, e[127-32*i -: 32], (i == 3));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_key_reuse;
        int n;
        logic [127:0] e;
        e = EXP2;
        sel = 1'b0; out_ready = 1'b1;
        load_block(DATA2, 1'b0);
        wait_out(n);
        checks++;
        if (core_key !== KEY || n !== 1) begin
            errors++;
            $display("FAIL reuse_key: core_key=%h latency=%0d, required %h / 1", core_key, n, KEY);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_word !== e[127-32*i -: 32] || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL reuse_word%0d: valid=%b word=%h last=%b, required 1 / %h / %b",
                         i, out_valid, out_word, out_last, e[127-32*i -: 32], (i == 3));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_send;
        int n;
        sel = 1'b0; out_ready = 1'b1;
        load_block(DATA, 1'b0);
        wait_out(n);
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h8090a0b0) begin
            errors++;
            $display("FAIL rst_pre: valid=%b word=%h, required 1 / 8090a0b0", out_valid, out_word);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || key_loaded !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: valid=%b key_loaded=%b busy=%b last=%b, required all 0",
                     out_valid, key_loaded, busy, out_last);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_more: valid=%b, required 0", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b1; in_is_key = 1'b0; in_word = 32'hcafef00d;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_refuse: in_ready=%b, required 0", in_ready);
        end
        in_valid = 1'b0;
        load_block(KEY, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_is_key = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || key_loaded !== 1'b1) begin
            errors++;
            $display("FAIL rst_reload: in_ready=%b key_loaded=%b, required 1 / 1", in_ready, key_loaded);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_wait4;
        int n;
        logic [127:0] e;
        e = EXP1;
        sel = 1'b1; out_ready = 1'b1;
        load_block(KEY, 1'b1);
        load_block(DATA, 1'b0);
        in_valid = 1'b1; in_is_key = 1'b1; in_word = 32'hffffffff;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL w4_inflight: in_ready=%b busy=%b, required 0 / 1", in_ready, busy);
        end
        in_valid = 1'b0;
        wait_out(n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL w4_latency: %0d edges, required 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_word !== e[127-32*i -: 32] || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL w4_word%0d: valid=%b word=%h last=%b, required 1 / %h / %b",
                         i, out_valid, out_word, out_last, e[127-32*i -: 32], (i == 3));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || core_key !== KEY) begin
            errors++;
            $display("FAIL w4_done: valid=%b core_key=%h, required 0 / %h", out_valid, core_key, KEY);
        end
    endtask

    initial begin
        test_reset();
        test_key_gate();
        test_basic();
        test_backpressure();
        test_key_reuse();
        test_reset_mid_send();
        test_wait4();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
